// File: rtl/sipo_frame_ctrl.sv
// Framed serial receiver: hunts for a start bit, shifts W data bits MSB-first,
// checks the stop bit and hands good words to a one-entry valid/ready buffer.
module sipo_frame_ctrl #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         sin_i,
  input  logic         sin_vld_i,
  input  logic         out_ready_i,
  input  logic         clr_err_i,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  output logic         busy_o,
  output logic         overflow_o,
  output logic         frame_err_o,
  output logic [15:0]  word_cnt_o
);

  localparam int CntW = $clog2(W);

  typedef enum logic [1:0] {IDLE, HUNT, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] bitCnt_q, bitCnt_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [W-1:0]    outData_q, outData_d;
  logic            outValid_q, outValid_d;
  logic            overflow_q, overflow_d;
  logic            frameErr_q, frameErr_d;
  logic [15:0]     wordCnt_q, wordCnt_d;

  logic goodStop, badStop;
  logic consume, load, dropWord;

  // Dropping en overrides everything so a partial frame is discarded at once.
  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    goodStop = 1'b0;
    badStop  = 1'b0;
    if (!en_i) begin
      state_d  = IDLE;
      bitCnt_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = HUNT;
        HUNT: begin
          if (sin_vld_i && sin_i) begin
            state_d  = DATA;
            bitCnt_d = '0;
          end
        end
        DATA: begin
          if (sin_vld_i) begin
            shift_d = {shift_q[W-2:0], sin_i};
            if (bitCnt_q == CntW'(W - 1)) begin
              state_d  = STOP;
              bitCnt_d = '0;
            end else begin
              bitCnt_d = bitCnt_q + CntW'(1);
            end
          end
        end
        STOP: begin
          if (sin_vld_i) begin
            state_d  = HUNT;
            goodStop = !sin_i;
            badStop  = sin_i;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A consume in the stop-bit cycle frees the buffer for the new word.
  always_comb begin
    consume    = outValid_q & out_ready_i;
    load       = goodStop & (~outValid_q | out_ready_i);
    dropWord   = goodStop & outValid_q & ~out_ready_i;
    outData_d  = load ? shift_q : outData_q;
    outValid_d = load | (outValid_q & ~out_ready_i);
    wordCnt_d  = wordCnt_q + {15'd0, consume};
    overflow_d = (overflow_q & ~clr_err_i) | dropWord;
    frameErr_d = (frameErr_q & ~clr_err_i) | badStop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      overflow_q <= 1'b0;
      frameErr_q <= 1'b0;
      wordCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      overflow_q <= overflow_d;
      frameErr_q <= frameErr_d;
      wordCnt_q  <= wordCnt_d;
    end
  end

  assign out_data_o  = outData_q;
  assign out_valid_o = outValid_q;
  assign busy_o      = (state_q == DATA) || (state_q == STOP);
  assign overflow_o  = overflow_q;
  assign frame_err_o = frameErr_q;
  assign word_cnt_o  = wordCnt_q;

endmodule
